// File: rtl/spif_pkg.sv
// Packet field layout shared by the SPIF transmit and receive paths.
package spif_pkg;

  localparam int unsigned PACKET_BITS     = 72;
  localparam int unsigned KEY_LSB         = 8;
  localparam int unsigned PAYLOAD_LSB     = 40;
  localparam int unsigned HDR_PARITY_BIT  = 0;
  localparam int unsigned HDR_PAYLOAD_BIT = 1;

  typedef struct packed {
    logic [31:0] payload;
    logic [31:0] key;
    logic [7:0]  header;
  } spif_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] request,
  input  logic                    advance,
  output logic [NUM_CHANNELS-1:0] grant
);

  localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Search requesters starting at the pointer, wrapping around
  always_comb begin
    grant    = '0;
    win_idx  = ptr_q;
    cand_idx = ptr_q;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      cand_idx = IDX_W'((32'(ptr_q) + k) % NUM_CHANNELS);
      if (!found && request[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  // Pointer moves past the winner only when its packet is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = IDX_W'((32'(win_idx) + 32'd1) % NUM_CHANNELS);
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pkt_transmitter.sv
// Multi-source packet transmitter: round-robin input arbitration, header
// parity insertion and a two-entry (main + skid) registered output buffer.
module pkt_transmitter #(
  parameter int unsigned PACKET_BITS  = spif_pkg::PACKET_BITS,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0] pkt_data_in,
  input  logic [NUM_CHANNELS-1:0]                 pkt_vld_in,
  output logic [NUM_CHANNELS-1:0]                 pkt_rdy_out,
  output logic [PACKET_BITS-1:0]                  pkt_data_out,
  output logic                                    pkt_vld_out,
  input  logic                                    pkt_rdy_in,
  output logic [NUM_CHANNELS-1:0]                 ptx_cnt_out
);

  localparam int unsigned CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned PAY_LSB = spif_pkg::PAYLOAD_LSB;
  localparam int unsigned PAR_BIT = spif_pkg::HDR_PARITY_BIT;
  localparam int unsigned PRS_BIT = spif_pkg::HDR_PAYLOAD_BIT;

  logic [NUM_CHANNELS-1:0] grant;
  logic                    space_c;
  logic                    in_xfer;
  logic                    out_xfer;
  logic [CH_W-1:0]         in_ch;
  logic [PACKET_BITS-1:0]  in_raw;
  logic [PACKET_BITS-1:0]  in_pkt;

  logic [PACKET_BITS-1:0]  data_q, data_d;
  logic                    vld_q, vld_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [PACKET_BITS-1:0]  skid_data_q, skid_data_d;
  logic                    skid_vld_q, skid_vld_d;
  logic [CH_W-1:0]         skid_ch_q, skid_ch_d;

  // A slot is free after this cycle unless both entries are held
  assign out_xfer    = vld_q & pkt_rdy_in;
  assign space_c     = ~skid_vld_q | pkt_rdy_in;
  assign pkt_rdy_out = (space_c && !reset) ? grant : '0;
  assign in_xfer     = |(pkt_vld_in & pkt_rdy_out);

  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .request (pkt_vld_in),
    .advance (in_xfer),
    .grant   (grant)
  );

  // Select the granted channel's packet and fix up its parity bit
  always_comb begin
    in_ch = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      if (grant[i]) in_ch = CH_W'(i);
    end
    in_raw = pkt_data_in[in_ch];
    in_pkt = in_raw;
    if (PARITY_EN) begin
      in_pkt[PAR_BIT] = in_raw[PRS_BIT] ? ~(^in_raw[PACKET_BITS-1:1])
                                        : ~(^in_raw[PAY_LSB-1:1]);
    end
  end

  // Main/skid buffer update: skid drains into main before new data
  always_comb begin
    data_d      = data_q;
    vld_d       = vld_q;
    ch_d        = ch_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ch_d   = skid_ch_q;
    if (!vld_q || pkt_rdy_in) begin
      if (skid_vld_q) begin
        data_d     = skid_data_q;
        vld_d      = 1'b1;
        ch_d       = skid_ch_q;
        skid_vld_d = in_xfer;
        if (in_xfer) begin
          skid_data_d = in_pkt;
          skid_ch_d   = in_ch;
        end
      end else begin
        vld_d = in_xfer;
        if (in_xfer) begin
          data_d = in_pkt;
          ch_d   = in_ch;
        end
      end
    end else if (in_xfer) begin
      skid_data_d = in_pkt;
      skid_vld_d  = 1'b1;
      skid_ch_d   = in_ch;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q      <= '0;
      vld_q       <= 1'b0;
      ch_q        <= '0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_ch_q   <= '0;
    end else begin
      data_q      <= data_d;
      vld_q       <= vld_d;
      ch_q        <= ch_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_ch_q   <= skid_ch_d;
    end
  end

  // Delivery pulse for the source channel of the packet leaving this cycle
  always_comb begin
    ptx_cnt_out = '0;
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      ptx_cnt_out[i] = out_xfer && !reset && (ch_q == CH_W'(i));
    end
  end

  assign pkt_data_out = data_q;
  assign pkt_vld_out  = vld_q;

endmodule

// File: tb/tb_pkt_transmitter.sv
// Bench for pkt_transmitter: parity-on and parity-off instances driven by the
// same valid/ready stimulus, checked every cycle against a queue-based model.
module tb_pkt_transmitter;

  localparam int unsigned NCH = 2;
  localparam int unsigned PB  = spif_pkg::PACKET_BITS;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCH-1:0][PB-1:0]  pkt_data_in;
  logic [NCH-1:0]          pkt_vld_in;
  logic                    pkt_rdy_in;
  logic [NCH-1:0]          pkt_rdy_out, pkt_rdy_out_np;
  logic [PB-1:0]           pkt_data_out, pkt_data_out_np;
  logic                    pkt_vld_out, pkt_vld_out_np;
  logic [NCH-1:0]          ptx_cnt_out, ptx_cnt_out_np;

  always #5 clk = ~clk;

  pkt_transmitter #(.PACKET_BITS(PB), .NUM_CHANNELS(NCH), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in),
    .pkt_rdy_out(pkt_rdy_out), .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out),
    .pkt_rdy_in(pkt_rdy_in), .ptx_cnt_out(ptx_cnt_out));

  pkt_transmitter #(.PACKET_BITS(PB), .NUM_CHANNELS(NCH), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .pkt_data_in(pkt_data_in), .pkt_vld_in(pkt_vld_in),
    .pkt_rdy_out(pkt_rdy_out_np), .pkt_data_out(pkt_data_out_np), .pkt_vld_out(pkt_vld_out_np),
    .pkt_rdy_in(pkt_rdy_in), .ptx_cnt_out(ptx_cnt_out_np));

  typedef struct {
    logic [PB-1:0] raw;
    logic [PB-1:0] par;
    int unsigned   ch;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned rr_start;
  bit          rst_seen;
  logic [NCH-1:0] acc_mask;
  int unsigned acc_cnt[NCH];
  int unsigned ptx_seen[NCH];
  int unsigned dut_acc;
  int unsigned dut_out;
  logic [NCH-1:0] src_on;
  int unsigned src_rate;
  int unsigned rdy_rate;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Odd parity over the whole packet (payload present) or the low 40 bits
  function automatic logic [PB-1:0] odd_fix(input logic [PB-1:0] raw);
    logic [PB-1:0] p;
    int unsigned   ones;
    p = raw;
    p[spif_pkg::HDR_PARITY_BIT] = 1'b0;
    if (p[spif_pkg::HDR_PAYLOAD_BIT]) ones = $countones(p);
    else                               ones = $countones(p[spif_pkg::PAYLOAD_LSB-1:0]);
    p[spif_pkg::HDR_PARITY_BIT] = ((ones % 2) == 0);
    return p;
  endfunction

  function automatic logic [PB-1:0] rand_pkt();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  // Compare this cycle's outputs with the model, then advance the model
  task automatic eval_cycle();
    logic [NCH-1:0] exp_rdy;
    logic [NCH-1:0] exp_ptx;
    int unsigned    occ;
    int unsigned    win;
    int unsigned    c;
    bit             out_x;
    bit             space;
    bit             any;
    exp_rdy = '0;
    exp_ptx = '0;
    occ     = exp_q.size();
    if (reset) begin
      check_eq("rst_rdy", pkt_rdy_out, '0);
      check_eq("rst_ptx", ptx_cnt_out, '0);
      check_eq("rst_rdy_np", pkt_rdy_out_np, '0);
      if (rst_seen) begin
        check_eq("rst_vld", pkt_vld_out, 1'b0);
        check_eq("rst_data", pkt_data_out, '0);
        check_eq("rst_vld_np", pkt_vld_out_np, 1'b0);
      end
      exp_q.delete();
      rr_start = 0;
      rst_seen = 1'b1;
      acc_mask = '0;
      return;
    end
    rst_seen = 1'b0;
    out_x = (occ > 0) && pkt_rdy_in;
    space = (occ - (out_x ? 1 : 0)) < 2;
    any = 1'b0;
    win = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      c = (rr_start + k) % NCH;
      if (!any && pkt_vld_in[c]) begin
        any = 1'b1;
        win = c;
      end
    end
    if (space && any) exp_rdy[win] = 1'b1;
    if (out_x) exp_ptx[exp_q[0].ch] = 1'b1;

    check_eq("vld_out", pkt_vld_out, occ > 0);
    check_eq("vld_out_np", pkt_vld_out_np, occ > 0);
    if (occ > 0) begin
      check_eq("data_out", pkt_data_out, exp_q[0].par);
      check_eq("data_out_np", pkt_data_out_np, exp_q[0].raw);
    end
    check_eq("rdy_out", pkt_rdy_out, exp_rdy);
    check_eq("rdy_out_np", pkt_rdy_out_np, exp_rdy);
    check_eq("ptx_cnt", ptx_cnt_out, exp_ptx);
    check_eq("ptx_cnt_np", ptx_cnt_out_np, exp_ptx);

    for (int i = 0; i < int'(NCH); i++) ptx_seen[i] += 32'(ptx_cnt_out[i]);
    dut_acc += 32'($countones(pkt_vld_in & pkt_rdy_out));
    dut_out += 32'(pkt_vld_out & pkt_rdy_in);

    if (out_x) void'(exp_q.pop_front());
    if (exp_rdy != '0) begin
      exp_q.push_back('{raw: pkt_data_in[win], par: odd_fix(pkt_data_in[win]), ch: win});
      rr_start = (win + 1) % NCH;
      acc_cnt[win]++;
    end
    acc_mask = exp_rdy & pkt_vld_in;
  endtask

  // Sources hold data until taken, then optionally offer a new packet
  task automatic drive();
    for (int c = 0; c < int'(NCH); c++) begin
      if (acc_mask[c]) pkt_vld_in[c] = 1'b0;
      if (!pkt_vld_in[c] && src_on[c] && ($urandom_range(99) < src_rate)) begin
        pkt_vld_in[c]  = 1'b1;
        pkt_data_in[c] = rand_pkt();
      end
    end
    pkt_rdy_in = ($urandom_range(99) < rdy_rate);
  endtask

  task automatic finish_step();
    eval_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    finish_step();
  endtask

  task automatic drain();
    src_on   = '0;
    rdy_rate = 100;
    pkt_rdy_in = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() > 0 || pkt_vld_in != '0); i++) step();
    check_eq("drain_empty", pkt_vld_out, 1'b0);
  endtask

  initial begin
    logic [PB-1:0] tmp;
    int unsigned   base;
    n_checks = 0;
    n_fail   = 0;
    rr_start = 0;
    rst_seen = 1'b0;
    acc_mask = '0;
    dut_acc  = 0;
    dut_out  = 0;
    for (int i = 0; i < int'(NCH); i++) begin
      acc_cnt[i]  = 0;
      ptx_seen[i] = 0;
    end
    src_on      = '0;
    src_rate    = 100;
    rdy_rate    = 0;
    reset       = 1'b1;
    pkt_vld_in  = '0;
    pkt_data_in = '0;
    pkt_rdy_in  = 1'b0;

    // Reset state
    repeat (3) step();
    reset = 1'b0;

    // Single ch1 packet, transceiver always ready
    rdy_rate = 100;
    pkt_rdy_in = 1'b1;
    tmp = {32'h0, 32'h0000_0100, 8'h00};
    pkt_vld_in[1]  = 1'b1;
    pkt_data_in[1] = tmp;
    repeat (4) step();

    // Both channels streaming: alternate grants, one packet per cycle
    src_on = 2'b11;
    pkt_vld_in = 2'b11;
    pkt_data_in[0] = rand_pkt();
    pkt_data_in[1] = rand_pkt();
    repeat (20) step();
    drain();

    // Diagnostic reply packet on ch0
    tmp = {32'h0000_000d, 32'hffff_fd41, 8'h32};
    pkt_vld_in[0]  = 1'b1;
    pkt_data_in[0] = tmp;
    repeat (4) step();

    // Stall with both channels streaming from an empty buffer
    rdy_rate = 0;
    pkt_rdy_in = 1'b0;
    src_on = 2'b11;
    pkt_vld_in = 2'b11;
    pkt_data_in[0] = rand_pkt();
    pkt_data_in[1] = rand_pkt();
    base = dut_acc;
    repeat (5) step();
    check_eq("stall_accepts", 128'(dut_acc - base), 128'd2);
    rdy_rate = 100;
    pkt_rdy_in = 1'b1;
    base = dut_out;
    for (int i = 0; i < 200 && (dut_out - base) < 40; i++) step();
    check_eq("stream40_done", 128'((dut_out - base) >= 40), 128'd1);
    drain();

    // Reset with two packets buffered
    rdy_rate = 0;
    pkt_rdy_in = 1'b0;
    src_on = 2'b11;
    pkt_vld_in = 2'b11;
    pkt_data_in[0] = rand_pkt();
    pkt_data_in[1] = rand_pkt();
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    rdy_rate = 100;
    pkt_rdy_in = 1'b1;
    @(negedge clk);
    check_eq("post_rst_grant", pkt_rdy_out, 2'b01);
    finish_step();
    repeat (10) step();
    drain();

    // Random valid/ready traffic with per-channel delivery accounting
    for (int i = 0; i < int'(NCH); i++) begin
      acc_cnt[i]  = 0;
      ptx_seen[i] = 0;
    end
    src_on   = 2'b11;
    src_rate = 50;
    for (int blk = 0; blk < 10; blk++) begin
      rdy_rate = $urandom_range(90, 20);
      repeat (1000) step();
    end
    drain();
    for (int i = 0; i < int'(NCH); i++) begin
      check_eq($sformatf("ptx_pulses_ch%0d", i), 128'(ptx_seen[i]), 128'(acc_cnt[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
